// File: rtl/aeolus_pkg.sv
// Shared Aeolus datapath constants: receiver FSM encoding and default word width.
package aeolus_pkg;

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_SHIFT = 2'd1;
  localparam logic [1:0] RX_HOLD  = 2'd2;

  localparam int AEOLUS_WORD_W = 4;

endpackage

// File: rtl/rx_bit_counter.sv
// Loadable frame-bit up-counter; done flags that the next strobed bit closes the frame.
module rx_bit_counter #(
  parameter int FRAME_LEN = 4,
  parameter int CNT_W     = $clog2(FRAME_LEN + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load1,
  input  logic inc,
  output logic done
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN - 1);

  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;

  // Wrap to zero on the closing bit so the counter is clean for the next frame.
  always_comb begin
    count_next = count_reg;
    if (load1) begin
      count_next = CNT_W'(1);
    end else if (inc) begin
      count_next = (count_reg == LAST) ? '0 : count_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign done = (count_reg == LAST);

endmodule

// File: rtl/serial_word_receiver.sv
// Serial-in, parallel-out word receiver with valid/ready output and sticky overrun flag.
// Optional even-parity trailer bit and PARITY_ERR output when SERIAL_PARITY_EN is defined.
module serial_word_receiver
  import aeolus_pkg::*;
#(
  parameter int WIDTH     = AEOLUS_WORD_W,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             SER_IN,
  input  logic             SER_VALID,
  output logic [WIDTH-1:0] OUT,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic             BUSY,
`ifdef SERIAL_PARITY_EN
  output logic             PARITY_ERR,
`endif
  output logic             FLAG
);

`ifdef SERIAL_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif

  logic [1:0]       state_reg, state_next;
  logic [WIDTH-1:0] sreg_reg, sreg_next;
  logic [WIDTH-1:0] out_reg, out_next;
  logic             out_valid_reg, out_valid_next;
  logic             flag_reg, flag_next;
  logic [WIDTH-1:0] shifted;
  logic             cnt_load1, cnt_inc, cnt_done;
`ifdef SERIAL_PARITY_EN
  logic             parity_err_reg, parity_err_next;
`endif

  rx_bit_counter #(
    .FRAME_LEN (FRAME_LEN),
    .CNT_W     ($clog2(WIDTH + 1))
  ) u_bit_counter (
    .clk   (CLK),
    .rst_n (RESET),
    .load1 (cnt_load1),
    .inc   (cnt_inc),
    .done  (cnt_done)
  );

  assign shifted = MSB_FIRST ? {sreg_reg[WIDTH-2:0], SER_IN}
                             : {SER_IN, sreg_reg[WIDTH-1:1]};

  always_comb begin
    state_next     = state_reg;
    sreg_next      = sreg_reg;
    out_next       = out_reg;
    out_valid_next = out_valid_reg;
    flag_next      = flag_reg;
    cnt_load1      = 1'b0;
    cnt_inc        = 1'b0;
`ifdef SERIAL_PARITY_EN
    parity_err_next = parity_err_reg;
`endif
    case (state_reg)
      RX_IDLE: begin
        if (SER_VALID) begin
          sreg_next  = shifted;
          cnt_load1  = 1'b1;
          state_next = RX_SHIFT;
        end
      end
      RX_SHIFT: begin
        if (SER_VALID) begin
          cnt_inc = 1'b1;
          if (cnt_done) begin
            state_next     = RX_HOLD;
            out_valid_next = 1'b1;
`ifdef SERIAL_PARITY_EN
            // Closing bit is the parity trailer: data is already complete in sreg.
            out_next        = sreg_reg;
            parity_err_next = SER_IN ^ (^sreg_reg);
`else
            sreg_next = shifted;
            out_next  = shifted;
`endif
          end else begin
            sreg_next = shifted;
          end
        end
      end
      RX_HOLD: begin
        if (OUT_READY) begin
          out_valid_next = 1'b0;
          // A bit arriving with the handshake starts the next frame without loss.
          if (SER_VALID) begin
            sreg_next  = shifted;
            cnt_load1  = 1'b1;
            state_next = RX_SHIFT;
          end else begin
            state_next = RX_IDLE;
          end
        end else if (SER_VALID) begin
          flag_next = 1'b1;
        end
      end
      default: begin
        state_next = RX_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_reg     <= RX_IDLE;
      sreg_reg      <= '0;
      out_reg       <= '0;
      out_valid_reg <= 1'b0;
      flag_reg      <= 1'b0;
`ifdef SERIAL_PARITY_EN
      parity_err_reg <= 1'b0;
`endif
    end else begin
      state_reg     <= state_next;
      sreg_reg      <= sreg_next;
      out_reg       <= out_next;
      out_valid_reg <= out_valid_next;
      flag_reg      <= flag_next;
`ifdef SERIAL_PARITY_EN
      parity_err_reg <= parity_err_next;
`endif
    end
  end

  assign OUT       = out_reg;
  assign OUT_VALID = out_valid_reg;
  assign BUSY      = (state_reg == RX_SHIFT);
  assign FLAG      = flag_reg;
`ifdef SERIAL_PARITY_EN
  assign PARITY_ERR = parity_err_reg;
`endif

endmodule
